// File: rtl/spi_master_shifter.sv
// spi_master_shifter
// SPI mode 0 (CPOL=0, CPHA=0), MSB-first master engine. It pops bytes from a
// TX FIFO, shifts them out on MOSI while sampling MISO on every SCLK rise, and
// pushes each received byte into an RX FIFO.
//
// Parameters:
//   DWIDTH   bits per SPI frame / FIFO word width (>= 2)
//   CLK_DIV  i_clk cycles per SCLK half-period (>= 1)
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   tx_empty           TX FIFO empty flag
//   tx_dataOut         TX FIFO read data, valid the cycle after the pop edge
//   tx_REn             TX FIFO pop strobe (one cycle per byte)
//   rx_full            RX FIFO full flag
//   rx_dataIn, rx_WEn  RX FIFO write data and push strobe
//   o_sclk, o_mosi     SPI clock (idles low) and data out
//   o_cs_n             SPI chip select, active low
//   i_miso             SPI data in, sampled on SCLK rise
//   busy               high whenever the engine is not idle
//   overrun            sticky: a received byte was dropped on rx_full
//   overrun_clr        synchronous clear of overrun (a same-cycle set wins)
//
// Build option:
//   SPI_CS_HOLD_EN  when defined, queued bytes are sent back to back with
//                   o_cs_n held low; otherwise o_cs_n deasserts between bytes.
//
// Frame timeline, relative to the o_cs_n fall (D = CLK_DIV):
//   D lead cycles, then DWIDTH bit periods of D low + D high cycles.
//   The last SCLK fall lands at D*(2*DWIDTH+1) and coincides with DONE entry;
//   rx_WEn follows one cycle later.

module spi_master_shifter #(
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              tx_empty,
    input  logic [DWIDTH-1:0] tx_dataOut,
    output logic              tx_REn,
    input  logic              rx_full,
    output logic [DWIDTH-1:0] rx_dataIn,
    output logic              rx_WEn,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
    input  logic              i_miso,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DWIDTH + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LEAD,
        SHIFT,
        DONE,
        GAP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DWIDTH-1:0] tx_sr;
    logic [DWIDTH-1:0] rx_sr;
    logic              fetch_wait;
    logic              half_done;

    // End of the current CLK_DIV-cycle interval
    assign half_done = (cnt == HALF_LAST);

    // Engine state and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            fetch_wait <= 1'b0;
            tx_REn     <= 1'b0;
            rx_WEn     <= 1'b0;
            rx_dataIn  <= '0;
            o_sclk     <= 1'b0;
            o_mosi     <= 1'b0;
            o_cs_n     <= 1'b1;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            tx_REn <= 1'b0;
            rx_WEn <= 1'b0;

            // Clear first so a set later in this block takes priority
            if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!tx_empty) begin
                        tx_REn     <= 1'b1;
                        fetch_wait <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end

                // First cycle covers the FIFO read latency, second loads the byte
                FETCH: begin
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else begin
                        tx_sr   <= tx_dataOut;
                        o_mosi  <= tx_dataOut[DWIDTH-1];
                        o_cs_n  <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= LEAD;
                    end
                end

                LEAD: begin
                    if (half_done) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Each bit: CLK_DIV cycles low, rise + sample, CLK_DIV high, fall + advance
                SHIFT: begin
                    if (!half_done) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (!o_sclk) begin
                            o_sclk <= 1'b1;
                            rx_sr  <= {rx_sr[DWIDTH-2:0], i_miso};
                        end else begin
                            o_sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                o_mosi <= 1'b0;
`ifndef SPI_CS_HOLD_EN
                                o_cs_n <= 1'b1;
`endif
                                state  <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                // Rotate rather than shift; the wrapped bit is never driven out
                                tx_sr   <= {tx_sr[DWIDTH-2:0], tx_sr[DWIDTH-1]};
                                o_mosi  <= tx_sr[DWIDTH-2];
                            end
                        end
                    end
                end

                DONE: begin
                    if (!rx_full) begin
                        rx_WEn    <= 1'b1;
                        rx_dataIn <= rx_sr;
                    end else begin
                        overrun <= 1'b1;
                    end
                    cnt <= '0;
`ifdef SPI_CS_HOLD_EN
                    // Keep the transaction open while more bytes are queued
                    if (!tx_empty) begin
                        tx_REn     <= 1'b1;
                        fetch_wait <= 1'b1;
                        state      <= FETCH;
                    end else begin
                        o_cs_n <= 1'b1;
                        state  <= GAP;
                    end
`else
                    state <= GAP;
`endif
                end

                GAP: begin
                    if (half_done) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter: behavioural TX/RX FIFO models,
// a per-cycle pin monitor, and frame-level expectations derived from the
// SPI mode 0 rules (byte order, pulse counts, chip-select windows, RX data).

module tb_spi_master_shifter;

    localparam int unsigned DW    = 8;
    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = DIV * (2 * DW + 1);

    logic          clk;
    logic          rst_n;
    logic          tx_empty;
    logic [DW-1:0] tx_dataOut;
    logic          tx_REn;
    logic          rx_full;
    logic [DW-1:0] rx_dataIn;
    logic          rx_WEn;
    logic          o_sclk;
    logic          o_mosi;
    logic          o_cs_n;
    logic          i_miso;
    logic          busy;
    logic          overrun;
    logic          overrun_clr;

    spi_master_shifter #(
        .DWIDTH (DW),
        .CLK_DIV(DIV)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .tx_empty   (tx_empty),
        .tx_dataOut (tx_dataOut),
        .tx_REn     (tx_REn),
        .rx_full    (rx_full),
        .rx_dataIn  (rx_dataIn),
        .rx_WEn     (rx_WEn),
        .o_sclk     (o_sclk),
        .o_mosi     (o_mosi),
        .o_cs_n     (o_cs_n),
        .i_miso     (i_miso),
        .busy       (busy),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_pass;

    // TX FIFO model
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pend_data;
    bit         pend_valid;

    // Monitor state
    int         cyc;
    bit         prev_sclk;
    bit         prev_cs_n;
    bit         prev_ren;
    bit         seen_low;
    int         cs_low_len;
    int         cs_high_len;
    int         cs_runs[$];
    int         gap_runs[$];
    bit         mosi_bits[$];
    bit         miso_bits[$];
    int         rises;
    int         ren_hi;
    int         ren_pulses;
    logic [7:0] wen_data[$];
    int         wen_delay[$];
    int         last_fall;
    bit         miso_drv;
    bit         loop_en;
    bit         idle_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_mon();
        prev_sclk   = o_sclk;
        prev_cs_n   = o_cs_n;
        prev_ren    = tx_REn;
        seen_low    = 1'b0;
        cs_low_len  = 0;
        cs_high_len = 0;
        cs_runs.delete();
        gap_runs.delete();
        mosi_bits.delete();
        miso_bits.delete();
        rises       = 0;
        ren_hi      = 0;
        ren_pulses  = 0;
        wen_data.delete();
        wen_delay.delete();
        last_fall   = cyc;
        idle_bad    = 1'b0;
    endtask

    // One clock: service the FIFO model, observe pins, drive MISO
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pend_valid) begin
            tx_dataOut = pend_data;
            pend_valid = 1'b0;
        end
        if (tx_REn && tx_q.size() > 0) begin
            pend_data  = tx_q.pop_front();
            pend_valid = 1'b1;
            tx_dataOut = ~pend_data;
        end
        tx_empty = (tx_q.size() == 0);

        if (o_sclk && !prev_sclk) begin
            rises++;
            mosi_bits.push_back(o_mosi);
            miso_bits.push_back(miso_drv);
        end
        if (!o_sclk && prev_sclk) last_fall = cyc;
        if (tx_REn) ren_hi++;
        if (tx_REn && !prev_ren) ren_pulses++;
        if (rx_WEn) begin
            wen_data.push_back(rx_dataIn);
            wen_delay.push_back(cyc - last_fall);
        end
        if (!o_cs_n) begin
            if (prev_cs_n && seen_low) gap_runs.push_back(cs_high_len);
            if (prev_cs_n) cs_high_len = 0;
            cs_low_len++;
            seen_low = 1'b1;
        end else begin
            if (!prev_cs_n) begin
                cs_runs.push_back(cs_low_len);
                cs_low_len = 0;
            end
            cs_high_len++;
        end
        if (tx_REn || o_sclk || busy || !o_cs_n) idle_bad = 1'b1;
        prev_sclk = o_sclk;
        prev_cs_n = o_cs_n;
        prev_ren  = tx_REn;

        miso_drv = loop_en ? o_mosi : 1'($urandom_range(0, 1));
        i_miso   = miso_drv;
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_q.push_back(b);
        exp_q.push_back(b);
        tx_empty = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((busy || tx_q.size() > 0 || pend_valid || !tx_empty) && n < 3000);
        check("drain_timeout", 32'(n >= 3000), 0);
        repeat (2) tick();
    endtask

    // Compare one drained batch against the frame-level expectations
    task automatic verify_batch(input bit full);
        int         n;
        logic [7:0] b;
        n = exp_q.size();
        check("ren_pulses", ren_pulses, n);
        check("ren_width", ren_hi, n);
        check("sclk_rises", rises, 8 * n);
        for (int k = 0; k < n; k++) begin
            b = '0;
            for (int i = 0; i < 8; i++)
                if (8 * k + i < mosi_bits.size()) b = {b[6:0], mosi_bits[8 * k + i]};
            check("mosi_byte", b, exp_q[k]);
        end
        check("wen_count", wen_data.size(), full ? 0 : n);
        for (int k = 0; k < wen_data.size(); k++) begin
            b = '0;
            for (int i = 0; i < 8; i++)
                if (8 * k + i < miso_bits.size()) b = {b[6:0], miso_bits[8 * k + i]};
            check("rx_byte", wen_data[k], b);
            check("wen_delay", wen_delay[k], 1);
        end
`ifdef SPI_CS_HOLD_EN
        check("cs_runs", cs_runs.size(), 1);
`else
        check("cs_runs", cs_runs.size(), n);
        for (int k = 0; k < cs_runs.size(); k++) check("cs_low_len", cs_runs[k], FRAME);
        check("cs_gaps", gap_runs.size(), n - 1);
        for (int k = 0; k < gap_runs.size(); k++) check("cs_gap_min", 32'(gap_runs[k] >= DIV), 1);
`endif
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int nb;
        bit full;
        n_checks    = 0;
        n_pass      = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        tx_empty    = 1'b1;
        tx_dataOut  = '0;
        rx_full     = 1'b0;
        i_miso      = 1'b0;
        overrun_clr = 1'b0;
        pend_valid  = 1'b0;
        loop_en     = 1'b0;
        miso_drv    = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_tx_REn", tx_REn, 0);
        check("rst_rx_WEn", rx_WEn, 0);
        check("rst_rx_data", rx_dataIn, 0);
        check("rst_sclk", o_sclk, 0);
        check("rst_mosi", o_mosi, 0);
        check("rst_cs_n", o_cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // Idle with an empty TX FIFO
        tick();
        clear_mon();
        repeat (100) tick();
        check("idle_quiet", idle_bad, 0);
        check("idle_no_pop", ren_hi, 0);

        // Single byte, random MISO
        clear_mon();
        push_byte(8'hA5);
        drain();
        verify_batch(1'b0);

        // Loopback
        clear_mon();
        loop_en = 1'b1;
        push_byte(8'h3C);
        drain();
        check("loop_wen_count", wen_data.size(), 1);
        if (wen_data.size() > 0) check("loop_data", wen_data[0], 8'h3C);
        verify_batch(1'b0);
        check("loop_overrun", overrun, 0);
        loop_en = 1'b0;

        // Two queued bytes
        clear_mon();
        push_byte(8'h01);
        push_byte(8'h80);
        drain();
        verify_batch(1'b0);

        // RX full: byte dropped, overrun raised and then cleared
        clear_mon();
        rx_full = 1'b1;
        push_byte(8'h5E);
        drain();
        verify_batch(1'b1);
        check("overrun_set", overrun, 1);
        rx_full     = 1'b0;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun_clr", overrun, 0);

        // Reset after the third SCLK rise
        clear_mon();
        push_byte(8'hC3);
        push_byte(8'h96);
        n = 0;
        while (rises < 3 && n < 1000) begin
            tick();
            n++;
        end
        check("rst_wait_timeout", 32'(n >= 1000), 0);
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", o_cs_n, 1);
        check("abort_sclk", o_sclk, 0);
        check("abort_busy", busy, 0);
        pend_valid = 1'b0;
        repeat (2) tick();
        check("abort_no_wen", wen_data.size(), 0);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        clear_mon();
        drain();
        verify_batch(1'b0);

        // Randomized batches
        for (int it = 0; it < 6; it++) begin
            overrun_clr = 1'b1;
            tick();
            overrun_clr = 1'b0;
            check("rand_overrun_clr", overrun, 0);
            clear_mon();
            full    = 1'($urandom_range(0, 3) == 0);
            loop_en = 1'($urandom_range(0, 1));
            rx_full = full;
            nb      = int'($urandom_range(1, 3));
            for (int k = 0; k < nb; k++) push_byte(8'($urandom));
            drain();
            verify_batch(full);
            check("rand_overrun", overrun, 32'(full));
            rx_full = 1'b0;
            loop_en = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
